// File: rtl/mem_rr_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of one synchronous single-port memory.
// Each transaction walks IDLE -> ACCESS -> RESP, so at most one access completes every
// three cycles. The memory samples addr/we at the end of ACCESS and returns read data
// during RESP, where it is passed straight through to the owning port.
module mem_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [CNT_WIDTH-1:0]  txn_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                state_q;
  logic                  rr_last_q;
  logic                  owner_q;
  logic                  op_we_q;
  logic                  mem_we_q;
  logic [1:0]            rsp_valid_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_in_q;
  logic [CNT_WIDTH-1:0]  txn_count_q;
  logic [CNT_WIDTH-1:0]  txn_count_d;

  logic                  any_valid;
  logic                  grant_d;
  logic [1:0]            ready_d;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + CNT_WIDTH'(1);
  endfunction

  // Arbitration: a lone requester wins; on contention the port that did not win last time wins.
  always_comb begin
    any_valid   = |req_valid;
    grant_d     = (&req_valid) ? ~rr_last_q : req_valid[1];
    ready_d     = 2'b00;
    if ((state_q == S_IDLE) && any_valid && !rst) begin
      ready_d = grant_d ? 2'b10 : 2'b01;
    end
    txn_count_d = sat_inc(txn_count_q);
  end

  // Sequencer FSM: latch the granted request, drive the memory for one cycle, then respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_last_q     <= 1'b1;
      owner_q       <= 1'b0;
      op_we_q       <= 1'b0;
      mem_we_q      <= 1'b0;
      rsp_valid_q   <= 2'b00;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      txn_count_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            mem_addr_q <= grant_d ? req_addr1 : req_addr0;
            op_we_q    <= req_we[grant_d];
            mem_we_q   <= req_we[grant_d];
            // Write data only moves for writes so the memory bus stays quiet on reads.
            if (req_we[grant_d]) begin
              mem_data_in_q <= grant_d ? req_wdata1 : req_wdata0;
            end
            owner_q   <= grant_d;
            rr_last_q <= grant_d;
            state_q   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          mem_we_q    <= 1'b0;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          rsp_valid_q <= 2'b00;
          txn_count_q <= txn_count_d;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = ready_d;
  assign rsp_valid   = rsp_valid_q;
  // Read data arrives from memory during RESP; writes and idle cycles return zero.
  assign rsp_rdata   = ((|rsp_valid_q) && !op_we_q) ? mem_data_out : '0;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_we      = mem_we_q;
  assign txn_count   = txn_count_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: a synchronous RAM model, a cycle model of the arbiter that
// pushes expected responses into a scoreboard queue on accept, and directed scenarios.
module tb_mem_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_we;
  logic [7:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [1:0] req_ready, rsp_valid;
  logic [7:0] rsp_rdata, mem_addr, mem_data_in;
  logic       mem_we;
  logic [7:0] mem_data_out;
  logic [15:0] txn_count;

  // Second instance with a 2-bit counter shares all inputs to exercise saturation.
  logic [1:0] req_ready2, rsp_valid2;
  logic [7:0] rsp_rdata2, mem_addr2, mem_data_in2;
  logic       mem_we2;
  logic [1:0] txn_count2;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] exp_q[$];
  int         glog[$];
  logic [9:0] rsp_log[$];
  logic       last_port;
  logic [7:0] last_data;
  int         we_cycles = 0;

  logic [7:0] ram [256];

  mem_rr_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we),
    .mem_data_out(mem_data_out), .txn_count(txn_count)
  );

  mem_rr_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .mem_addr(mem_addr2), .mem_data_in(mem_data_in2), .mem_we(mem_we2),
    .mem_data_out(mem_data_out), .txn_count(txn_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read single-port RAM.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_data_in;
    mem_data_out <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cycle model and scoreboard, evaluated on the falling edge.
  initial begin : model
    int         m_state;
    logic       m_rr_last, m_we, g, w;
    logic [7:0] m_addr, m_wdata, a, d, e_rd;
    logic [15:0] m_count;
    logic [1:0] m_count2, e_ready, e_rv;
    logic [9:0] e;
    logic       e_we;
    logic [7:0] ref_mem [256];
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    m_state = 0; m_rr_last = 1'b1; m_we = 1'b0; m_addr = 8'h00; m_wdata = 8'h00;
    m_count = 16'h0; m_count2 = 2'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_state = 0; m_rr_last = 1'b1; m_we = 1'b0; m_addr = 8'h00; m_wdata = 8'h00;
        m_count = 16'h0; m_count2 = 2'h0;
        exp_q.delete();
        check("rst_outputs", {req_ready, rsp_valid, mem_we, rsp_rdata, mem_addr, mem_data_in, txn_count}, 64'h0);
        check("rst_outputs2", {req_ready2, rsp_valid2, mem_we2, rsp_rdata2, mem_addr2, mem_data_in2, txn_count2}, 64'h0);
      end else begin
        e_ready = 2'b00; e_rv = 2'b00; e_rd = 8'h00; e_we = 1'b0; g = 1'b0;
        case (m_state)
          0: begin
            if (req_valid != 2'b00) begin
              g = (req_valid == 2'b11) ? !m_rr_last : req_valid[1];
              e_ready = g ? 2'b10 : 2'b01;
            end
          end
          1: e_we = m_we;
          default: begin
            if (exp_q.size() == 0) begin
              check("rsp_queue_empty", 64'd0, 64'd1);
            end else begin
              e = exp_q.pop_front();
              e_rv = e[9:8];
              e_rd = e[7:0];
            end
          end
        endcase
        if (mem_we) we_cycles++;
        check("req_ready", req_ready, e_ready);
        check("mem_we", mem_we, e_we);
        check("rsp_valid", rsp_valid, e_rv);
        check("rsp_rdata", rsp_rdata, e_rd);
        check("mem_addr", mem_addr, m_addr);
        check("mem_data_in", mem_data_in, m_wdata);
        check("txn_count", txn_count, m_count);
        check("dut2_outputs", {req_ready2, mem_we2, rsp_valid2, rsp_rdata2, mem_addr2, mem_data_in2, txn_count2},
              {e_ready, e_we, e_rv, e_rd, m_addr, m_wdata, m_count2});
        case (m_state)
          0: begin
            if (req_valid != 2'b00) begin
              w = req_we[g];
              a = g ? req_addr1 : req_addr0;
              d = g ? req_wdata1 : req_wdata0;
              exp_q.push_back({(g ? 2'b10 : 2'b01), (w ? 8'h00 : ref_mem[a])});
              if (w) begin
                ref_mem[a] = d;
                m_wdata = d;
              end
              m_addr = a; m_we = w; m_rr_last = g;
              glog.push_back(int'(g));
              m_state = 1;
            end
          end
          1: m_state = 2;
          default: begin
            last_port = rsp_valid[1];
            last_data = rsp_rdata;
            rsp_log.push_back({rsp_valid, rsp_rdata});
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            if (m_count2 != 2'b11) m_count2 = m_count2 + 2'd1;
            m_state = 0;
          end
        endcase
      end
    end
  end

  // Single-port request: hold valid until accepted (bounded), then drop it.
  task automatic req(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
    bit done;
    done = 0;
    if (p == 0) begin req_we[0] = we; req_addr0 = a; req_wdata0 = d; end
    else        begin req_we[1] = we; req_addr1 = a; req_wdata1 = d; end
    req_valid[p] = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready[p]) done = 1;
    end
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    if (!done) check("req_timeout", 64'd0, 64'd1);
  endtask

  // Both ports request together; each drops valid once its own request is taken.
  task automatic req_both(input logic we0, input logic [7:0] a0, input logic [7:0] d0,
                          input logic we1, input logic [7:0] a1, input logic [7:0] d1);
    logic [1:0] acc;
    req_we = {we1, we0};
    req_addr0 = a0; req_wdata0 = d0;
    req_addr1 = a1; req_wdata1 = d1;
    req_valid = 2'b11;
    for (int i = 0; i < 30 && req_valid != 2'b00; i++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
    end
    if (req_valid != 2'b00) begin
      check("req_both_timeout", 64'd0, 64'd1);
      req_valid = 2'b00;
    end
  endtask

  // Wait until every expected response has been seen, plus one settle cycle.
  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) ok = 1;
    end
    #1;
    @(posedge clk); #1;
    if (!ok) check("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base_we;
    int base_cnt;
    rst = 1'b1;
    req_valid = 2'b00; req_we = 2'b00;
    req_addr0 = 8'h00; req_addr1 = 8'h00; req_wdata0 = 8'h00; req_wdata1 = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single write, then read back from the other port.
    base_we = we_cycles;
    req(0, 1'b1, 8'h00, 8'h55);
    drain();
    check("t1_port", last_port, 1'b0);
    check("t1_rdata", last_data, 8'h00);
    check("t1_we_cycles", we_cycles - base_we, 1);
    check("t1_count", txn_count, 16'd1);
    req(1, 1'b0, 8'h00, 8'h00);
    drain();
    check("t2_port", last_port, 1'b1);
    check("t2_rdata", last_data, 8'h55);

    // Contention straight out of reset.
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    glog.delete();
    req_both(1'b1, 8'h01, 8'h66, 1'b1, 8'h02, 8'h77);
    drain();
    check("t3_ngrants", glog.size(), 2);
    if (glog.size() >= 2) begin
      check("t3_grant0", glog[0], 0);
      check("t3_grant1", glog[1], 1);
    end
    glog.delete();
    rsp_log.delete();
    req_both(1'b0, 8'h01, 8'h00, 1'b0, 8'h02, 8'h00);
    drain();
    check("t3_nrsp", rsp_log.size(), 2);
    if (rsp_log.size() >= 2) begin
      check("t3_rsp0", rsp_log[0], {2'b01, 8'h66});
      check("t3_rsp1", rsp_log[1], {2'b10, 8'h77});
    end

    // Fairness: both ports hold valid for 12 cycles.
    glog.delete();
    base_cnt = int'(txn_count);
    req_we = 2'b00; req_addr0 = 8'h01; req_addr1 = 8'h02;
    req_valid = 2'b11;
    repeat (12) @(posedge clk);
    #1 req_valid = 2'b00;
    drain();
    check("t4_ngrants", glog.size(), 4);
    for (int i = 0; i < glog.size(); i++) check("t4_grant", glog[i], i % 2);
    check("t4_count_delta", int'(txn_count) - base_cnt, 4);

    // Reset while a read sits in ACCESS.
    req_we[0] = 1'b0; req_addr0 = 8'h01; req_valid[0] = 1'b1;
    for (int i = 0; i < 20 && !req_ready[0]; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("t5_addr_before", mem_addr, 8'h01);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_immediate", {req_ready, rsp_valid, mem_we, rsp_rdata, mem_addr, mem_data_in, txn_count}, 64'h0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    glog.delete();
    rsp_log.delete();
    req_both(1'b1, 8'h03, 8'h11, 1'b0, 8'h01, 8'h00);
    drain();
    check("t5_ngrants", glog.size(), 2);
    if (glog.size() >= 1) check("t5_first_grant", glog[0], 0);
    check("t5_nrsp", rsp_log.size(), 2);
    if (rsp_log.size() >= 2) begin
      check("t5_rsp0", rsp_log[0], {2'b01, 8'h00});
      check("t5_rsp1", rsp_log[1], {2'b10, 8'h66});
    end
    check("t5_count", txn_count, 16'd2);

    // Saturation of the narrow counter over five transactions.
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    base_we = we_cycles;
    for (int i = 0; i < 5; i++) req(0, 1'b1, 8'(8'h10 + i), 8'(8'hA0 + i));
    drain();
    check("t6_count_wide", txn_count, 16'd5);
    check("t6_count_sat", txn_count2, 2'd3);
    check("t6_we_cycles", we_cycles - base_we, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
